tt_query_driver: RTL and testbench

//  Host-side transmitter for the TT shortest-path engine's edge-stream protocol.

---
 rtl/tt_query_driver.sv | 191 +++++++++++++++++++
 tb/tb_tt_query_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_query_driver.sv
// Host-side transmitter for the TT shortest-path engine edge-stream protocol.
// Buffers one query plus up to EDGE_DEPTH edges, bursts them to TT, then
// returns TT's cost (or a timeout) to the host over a valid/ready handshake.
module tt_query_driver #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned EDGE_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_is_query,
    input  logic [DATA_WIDTH-1:0] cfg_a,
    input  logic [DATA_WIDTH-1:0] cfg_b,
    input  logic                  start,
    output logic                  busy,
    output logic                  tt_in_valid,
    output logic [DATA_WIDTH-1:0] tt_source,
    output logic [DATA_WIDTH-1:0] tt_destination,
    input  logic                  tt_out_valid,
    input  logic [DATA_WIDTH-1:0] tt_cost,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_cost,
    output logic                  res_timeout
);

    localparam int unsigned CNT_W = $clog2(EDGE_DEPTH + 1);
    localparam int unsigned IDX_W = (EDGE_DEPTH > 1) ? $clog2(EDGE_DEPTH) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        QUERY  = 3'd1,
        EDGES  = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4,
        GAP    = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] q_src;
    logic [DATA_WIDTH-1:0] q_dst;
    logic                  query_loaded;
    logic [CNT_W-1:0]      edge_cnt;
    logic [CNT_W-1:0]      rd_ptr;
    logic [TO_W-1:0]       wait_cnt;
    logic [TO_W-1:0]       wait_cnt_inc;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] edge_a [EDGE_DEPTH];
    logic [DATA_WIDTH-1:0] edge_b [EDGE_DEPTH];

    logic cfg_fire;
    logic query_fire;
    logic edge_fire;
    logic launch;
    logic edges_done;
    logic wait_last;
    logic gap_last;

    // Host-side handshake and launch qualification.
    always_comb begin
        cfg_ready  = !rst && (state == LOAD) &&
                     (cfg_is_query || (edge_cnt < CNT_W'(EDGE_DEPTH)));
        busy       = (state != LOAD);
        cfg_fire   = cfg_valid && cfg_ready;
        query_fire = cfg_fire && cfg_is_query;
        edge_fire  = cfg_fire && !cfg_is_query;
        launch     = (state == LOAD) && start && (query_loaded || query_fire);
        edges_done = (rd_ptr == edge_cnt);
        wait_cnt_inc = (wait_cnt == TO_W'(TIMEOUT_CYCLES)) ? wait_cnt : wait_cnt + TO_W'(1);
        wait_last  = (wait_cnt_inc == TO_W'(TIMEOUT_CYCLES));
        gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:   if (launch) state_next = QUERY;
            QUERY:  state_next = (edge_cnt == '0) ? WAIT : EDGES;
            EDGES:  if (edges_done) state_next = WAIT;
            WAIT:   if (tt_out_valid || wait_last) state_next = RESULT;
            RESULT: if (res_ready) state_next = (GAP_CYCLES == 0) ? LOAD : GAP;
            GAP:    if (gap_last) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Edge buffer storage; contents are only meaningful below edge_cnt.
    always_ff @(posedge clk) begin
        if (edge_fire) begin
            edge_a[edge_cnt[IDX_W-1:0]] <= cfg_a;
            edge_b[edge_cnt[IDX_W-1:0]] <= cfg_b;
        end
    end

    // Datapath: query register, counters, registered TT and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_src          <= '0;
            q_dst          <= '0;
            query_loaded   <= 1'b0;
            edge_cnt       <= '0;
            rd_ptr         <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            tt_in_valid    <= 1'b0;
            tt_source      <= '0;
            tt_destination <= '0;
            res_valid      <= 1'b0;
            res_cost       <= '0;
            res_timeout    <= 1'b0;
        end else begin
            tt_in_valid    <= 1'b0;
            tt_source      <= '0;
            tt_destination <= '0;
            case (state)
                LOAD: begin
                    if (query_fire) begin
                        q_src        <= cfg_a;
                        q_dst        <= cfg_b;
                        query_loaded <= 1'b1;
                    end
                    if (edge_fire) edge_cnt <= edge_cnt + CNT_W'(1);
                    if (launch) begin
                        tt_in_valid    <= 1'b1;
                        tt_source      <= query_fire ? cfg_a : q_src;
                        tt_destination <= query_fire ? cfg_b : q_dst;
                    end
                end
                QUERY: begin
                    wait_cnt <= '0;
                    if (edge_cnt != '0) begin
                        tt_in_valid    <= 1'b1;
                        tt_source      <= edge_a[0];
                        tt_destination <= edge_b[0];
                        rd_ptr         <= CNT_W'(1);
                    end
                end
                EDGES: begin
                    wait_cnt <= '0;
                    if (!edges_done) begin
                        tt_in_valid    <= 1'b1;
                        tt_source      <= edge_a[rd_ptr[IDX_W-1:0]];
                        tt_destination <= edge_b[rd_ptr[IDX_W-1:0]];
                        rd_ptr         <= rd_ptr + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (tt_out_valid) begin
                        res_valid   <= 1'b1;
                        res_cost    <= tt_cost;
                        res_timeout <= 1'b0;
                    end else if (wait_last) begin
                        res_valid   <= 1'b1;
                        res_cost    <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        edge_cnt     <= '0;
                        rd_ptr       <= '0;
                        query_loaded <= 1'b0;
                        gap_cnt      <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_query_driver.sv
// Directed self-checking bench for tt_query_driver.
module tb_tt_query_driver;

    localparam int unsigned DW = 4;
    localparam int unsigned TO = 1023;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_is_query;
    logic [DW-1:0] cfg_a;
    logic [DW-1:0] cfg_b;
    logic          start;
    logic          busy;
    logic          tt_in_valid;
    logic [DW-1:0] tt_source;
    logic [DW-1:0] tt_destination;
    logic          tt_out_valid;
    logic [DW-1:0] tt_cost;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_cost;
    logic          res_timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_beats[$];

    tt_query_driver #(
        .DATA_WIDTH(DW), .EDGE_DEPTH(16), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_query(cfg_is_query),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .start(start), .busy(busy),
        .tt_in_valid(tt_in_valid), .tt_source(tt_source), .tt_destination(tt_destination),
        .tt_out_valid(tt_out_valid), .tt_cost(tt_cost),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_cost(res_cost), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic q, input int a, input int b);
        cfg_valid    = 1'b1;
        cfg_is_query = q;
        cfg_a        = DW'(a);
        cfg_b        = DW'(b);
        step();
        cfg_valid    = 1'b0;
        cfg_is_query = 1'b0;
    endtask

    // Pulse start, then capture consecutive in_valid beats against exp_beats.
    task automatic run_burst(input int n_exp, input string tag);
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (tt_in_valid === 1'b1 && n < 40) begin
            if (n < exp_beats.size())
                chk({tag, "_beat"}, 32'({tt_source, tt_destination}), 32'(exp_beats[n]));
            n++;
            step();
        end
        chk({tag, "_len"}, 32'(n), 32'(n_exp));
        chk({tag, "_idle_src"}, 32'({tt_source, tt_destination}), 32'h0);
    endtask

    // TT model answers one cycle into WAIT; result must appear promptly.
    task automatic respond(input int cost, input string tag);
        int n;
        tt_out_valid = 1'b1;
        tt_cost      = DW'(cost);
        step();
        tt_out_valid = 1'b0;
        tt_cost      = '0;
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_res_valid"}, 32'(res_valid), 32'h1);
        chk({tag, "_res_cost"}, 32'(res_cost), 32'(cost));
        chk({tag, "_res_timeout"}, 32'(res_timeout), 32'h0);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_valid = 1'b0; cfg_is_query = 1'b0; cfg_a = '0; cfg_b = '0;
        start = 1'b0; tt_out_valid = 1'b0; tt_cost = '0; res_ready = 1'b0;
        #12;
        chk("rst_in_valid", 32'(tt_in_valid), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_res", 32'({res_cost, res_timeout}), 32'h0);
        rst = 1'b0;
        step();
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // Test 1: query + 3 edges.
        load_beat(1'b1, 0, 3);
        load_beat(1'b0, 0, 1);
        load_beat(1'b0, 1, 2);
        load_beat(1'b0, 2, 3);
        exp_beats = '{8'h03, 8'h01, 8'h12, 8'h23};
        run_burst(4, "t1");
        chk("t1_busy_wait", 32'(busy), 32'h1);
        respond(3, "t1");
        handshake();

        // Test 2: full buffer, 17th edge refused, query still accepted.
        for (int i = 0; i < 16; i++) load_beat(1'b0, i, 15 - i);
        cfg_valid = 1'b1; cfg_is_query = 1'b0; cfg_a = 4'h9; cfg_b = 4'h9;
        #1;
        chk("t2_full_edge_ready", 32'(cfg_ready), 32'h0);
        cfg_is_query = 1'b1;
        #1;
        chk("t2_full_query_ready", 32'(cfg_ready), 32'h1);
        cfg_valid = 1'b0; cfg_is_query = 1'b0;
        load_beat(1'b1, 7, 9);
        exp_beats = '{8'h79};
        for (int i = 0; i < 16; i++) exp_beats.push_back({4'(i), 4'(15 - i)});
        run_burst(17, "t2");
        respond(5, "t2");
        handshake();

        // Test 3: query only, single-beat burst, zero cost.
        load_beat(1'b1, 5, 5);
        exp_beats = '{8'h55};
        run_burst(1, "t3");
        respond(0, "t3");
        handshake();

        // Test 4: TT never answers -> timeout after TIMEOUT_CYCLES WAIT cycles.
        load_beat(1'b1, 1, 2);
        load_beat(1'b0, 1, 2);
        exp_beats = '{8'h12, 8'h12};
        run_burst(2, "t4");
        n = 0;
        while (res_valid !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        chk("t4_timeout_latency", 32'(n), 32'(TO));
        chk("t4_res_timeout", 32'(res_timeout), 32'h1);
        chk("t4_res_cost", 32'(res_cost), 32'h0);

        // Test 5: host stalls; result stable, start and late tt_out_valid ignored.
        for (int i = 0; i < 10; i++) begin
            start        = (i == 3);
            tt_out_valid = (i == 5);
            tt_cost      = 4'h7;
            step();
            chk("t5_hold", 32'({res_valid, res_timeout, res_cost, tt_in_valid, busy}),
                32'({1'b1, 1'b1, 4'h0, 1'b0, 1'b1}));
        end
        start = 1'b0; tt_out_valid = 1'b0; tt_cost = '0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("t5_res_drop", 32'(res_valid), 32'h0);
        chk("t5_gap0_ready", 32'(cfg_ready), 32'h0);
        step();
        chk("t5_gap1_ready", 32'(cfg_ready), 32'h0);
        step();
        chk("t5_load_ready", 32'(cfg_ready), 32'h1);
        chk("t5_load_busy", 32'(busy), 32'h0);

        // Test 6: reset during EDGES; stale query must not relaunch.
        load_beat(1'b1, 2, 4);
        load_beat(1'b0, 2, 3);
        load_beat(1'b0, 3, 4);
        load_beat(1'b0, 4, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t6_pre_rst_valid", 32'(tt_in_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_in_valid", 32'(tt_in_valid), 32'h0);
        chk("t6_rst_src", 32'({tt_source, tt_destination}), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        #3;
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (tt_in_valid === 1'b1 || busy === 1'b1) n++;
            step();
        end
        chk("t6_no_burst", 32'(n), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
